load_store_unit: RTL and testbench

Memory-stage controller between the LEGv8 pipeline's execute/memory boundary and the word-organised data memory (256 × 32-bit words, 8-bit word address, level-sensitive read/write flags, combinational read data). It accepts byte-addressed load/store requests of byte, halfword or word size over a valid/ready handshake. It performs alignment checking, little-endian lane selection and sign/zero extension. Sub-word stores are done as read-modify-write. Results return over a valid/ready response channel.

---
 rtl/legv8_mem_pkg.sv | 31 +++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/lsu_lane_ctrl.sv | 54 +++++
 rtl/load_store_unit.sv | 122 ++++++++++++
 tb/tb_load_store_unit.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_mem_pkg.sv
// Shared definitions for the LEGv8 memory stage: access-size codes,
// load/store unit state encoding and the alignment rule.
package legv8_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_t;

  // The reserved size code 2'b11 is reported here too, so one call
  // decides whether a request faults.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic r_bad;
    r_bad = 1'b1;
    case (size)
      SZ_BYTE: r_bad = 1'b0;
      SZ_HALF: r_bad = addr_lo[0];
      SZ_WORD: r_bad = |addr_lo;
      default: r_bad = 1'b1;
    endcase
    return r_bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response channels between the pipeline and the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/lsu_lane_ctrl.sv
// Little-endian lane logic: load extraction/extension and sub-word
// store merge into an existing memory word.
module lsu_lane_ctrl
  import legv8_mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  logic [1:0]  i_size,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;
  logic [31:0] w_mask;
  logic [31:0] w_ins;

  assign w_shamt   = {i_offset, 3'b000};
  assign w_shifted = i_word >> w_shamt;

  // Bring the addressed lane down to bit 0 and extend it.
  always_comb begin
    o_load = i_word;
    case (i_size)
      SZ_BYTE: o_load = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_load = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: o_load = i_word;
    endcase
  end

  // Replace only the addressed lanes of the old word with the store data.
  always_comb begin
    w_mask = 32'hFFFF_FFFF;
    w_ins  = i_wdata;
    case (i_size)
      SZ_BYTE: begin
        w_mask = 32'h0000_00FF << w_shamt;
        w_ins  = {24'd0, i_wdata[7:0]} << w_shamt;
      end
      SZ_HALF: begin
        w_mask = 32'h0000_FFFF << w_shamt;
        w_ins  = {16'd0, i_wdata[15:0]} << w_shamt;
      end
      default: begin
        w_mask = 32'hFFFF_FFFF;
        w_ins  = i_wdata;
      end
    endcase
    o_merged = (i_word & ~w_mask) | (w_ins & w_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store controller for a 256 x 32-bit word memory.
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | ready for a request; captures fields and checks alignment
// RD      | memory read; loads extract, sub-word stores merge
// WR      | single-cycle memory write of the full word
// RESP    | response held until the consumer takes it
module load_store_unit
  import legv8_mem_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  load_store_unit_if.slave   bus,
  output logic               read_data_flag,
  output logic               write_data_flag,
  output logic [7:0]         address_of_data,
  output logic [31:0]        data_to_write,
  input  logic [31:0]        data_read_out
);

  lsu_state_t  r_state;
  lsu_state_t  w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [9:0]  r_addr;
  logic        r_fault;
  logic [31:0] r_rdata;
  // Holds the captured store data until RD, then the merged word for WR.
  logic [31:0] r_dtw;

  logic        w_accept;
  logic        w_fault;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept = (r_state == ST_IDLE) && bus.req_valid;
  assign w_fault  = is_misaligned(bus.req_size, bus.req_addr[1:0]);

  lsu_lane_ctrl u_lane (
    .i_word   (data_read_out),
    .i_offset (r_addr[1:0]),
    .i_size   (r_size),
    .i_signed (r_signed),
    .i_wdata  (r_dtw),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  // Next-state decode and per-state handshake/memory strobes.
  always_comb begin
    w_next          = r_state;
    bus.req_ready   = 1'b0;
    bus.resp_valid  = 1'b0;
    read_data_flag  = 1'b0;
    write_data_flag = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          if (w_fault)                                      w_next = ST_RESP;
          else if (bus.req_write && bus.req_size == SZ_WORD) w_next = ST_WR;
          else                                              w_next = ST_RD;
        end
      end
      ST_RD: begin
        read_data_flag = 1'b1;
        w_next = r_write ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        write_data_flag = 1'b1;
        w_next = ST_RESP;
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State register; async reset drops any in-flight access at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Request capture, load result and store word registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write  <= 1'b0;
      r_size   <= SZ_BYTE;
      r_signed <= 1'b0;
      r_addr   <= 10'd0;
      r_fault  <= 1'b0;
      r_rdata  <= 32'd0;
      r_dtw    <= 32'd0;
    end else begin
      if (w_accept) begin
        r_write  <= bus.req_write;
        r_size   <= bus.req_size;
        r_signed <= bus.req_signed;
        r_addr   <= bus.req_addr;
        r_fault  <= w_fault;
        r_rdata  <= 32'd0;
        if (bus.req_write) r_dtw <= bus.req_wdata;
      end
      if (r_state == ST_RD) begin
        if (r_write) r_dtw   <= w_merged;
        else         r_rdata <= w_load;
      end
    end
  end

  assign address_of_data = r_addr[9:2];
  assign data_to_write   = r_dtw;
  assign bus.resp_rdata  = r_rdata;
  assign bus.resp_fault  = r_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: bench-side word memory, byte-level reference
// model and a per-cycle response/strobe checker.
module tb_load_store_unit;
  import legv8_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  load_store_unit_if bus ();
  logic        read_data_flag;
  logic        write_data_flag;
  logic [7:0]  address_of_data;
  logic [31:0] data_to_write;
  logic [31:0] data_read_out;

  load_store_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .read_data_flag  (read_data_flag),
    .write_data_flag (write_data_flag),
    .address_of_data (address_of_data),
    .data_to_write   (data_to_write),
    .data_read_out   (data_read_out)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT, with a backdoor for preloading.
  logic [31:0] mem [256];
  logic        bd_en = 1'b0;
  logic        bd_clr = 1'b0;
  logic [7:0]  bd_addr = 8'd0;
  logic [31:0] bd_data = 32'd0;

  always @(posedge clk) begin
    if (bd_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    end else if (bd_en) begin
      mem[bd_addr] <= bd_data;
    end else if (write_data_flag) begin
      mem[address_of_data] <= data_to_write;
    end
  end
  assign data_read_out = mem[address_of_data];

  // Reference model state.
  logic [31:0] ref_mem [256];
  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int g_lat, g_rd, g_wr;
  logic [9:0] g_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_fault(input logic [1:0] sz, input logic [9:0] a);
    int n;
    if (sz == 2'b11) return 1'b1;
    n = 1 << sz;
    return (int'(a) % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [9:0] a,
                                             input logic [1:0] sz, input logic sg);
    logic [7:0]  b [4];
    logic [31:0] v;
    int off;
    for (int k = 0; k < 4; k++) b[k] = word[8*k +: 8];
    off = int'(a[1:0]);
    case (sz)
      2'b00: begin
        v = {24'd0, b[off]};
        if (sg && b[off][7]) v = v | 32'hFFFF_FF00;
      end
      2'b01: begin
        v = {16'd0, b[off+1], b[off]};
        if (sg && b[off+1][7]) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [9:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [7:0] b [4];
    int off, n;
    for (int k = 0; k < 4; k++) b[k] = old[8*k +: 8];
    off = int'(a[1:0]);
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    for (int k = 0; k < n; k++) b[off+k] = wd[8*k +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Per-cycle checker: strobe legality and response contents.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("flags_exclusive", {31'd0, read_data_flag && write_data_flag}, 32'd0);
      chk("flags_quiet", {31'd0, (bus.req_ready || bus.resp_valid) &&
                                 (read_data_flag || write_data_flag)}, 32'd0);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got resp_valid=1, expected no response (t=%0t)", $time);
        end else begin
          chk("resp_rdata", bus.resp_rdata, exp_q[0].rdata);
          chk("resp_fault", {31'd0, bus.resp_fault}, {31'd0, exp_q[0].fault});
          if (bus.resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic poke(input int idx, input logic [31:0] d);
    bd_en = 1'b1; bd_addr = 8'(idx); bd_data = d;
    @(posedge clk); #1;
    bd_en = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic clear_mem();
    bd_clr = 1'b1;
    @(posedge clk); #1;
    bd_clr = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
  endtask

  task automatic present(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [9:0] a, input logic [31:0] wd, input logic commit);
    exp_t e;
    int idx;
    idx = int'(a[9:2]);
    e.fault = model_fault(sz, a);
    e.rdata = (e.fault || w) ? 32'd0 : model_load(ref_mem[idx], a, sz, sg);
    if (w && !e.fault && commit) ref_mem[idx] = model_store(ref_mem[idx], a, sz, wd);
    g_lat  = e.fault ? 1 : (w && sz != SZ_WORD) ? 3 : 2;
    g_rd   = (e.fault || (w && sz == SZ_WORD)) ? 0 : 1;
    g_wr   = (!e.fault && w) ? 1 : 0;
    g_addr = a;
    if (commit) exp_q.push_back(e);
    bus.req_write  = w;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
  endtask

  task automatic wait_accept();
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.req_ready) begin ok = 1'b1; break; end
    end
    chk("accept_in_time", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 10'($urandom);
    bus.req_wdata = $urandom;
  endtask

  task automatic accept_and_measure();
    int lat, rd, wr;
    wait_accept();
    lat = 0; rd = 0; wr = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (read_data_flag)  rd++;
      if (write_data_flag) wr++;
      if (read_data_flag || write_data_flag)
        chk("mem_word_addr", {24'd0, address_of_data}, {24'd0, g_addr[9:2]});
      if (bus.resp_valid) begin lat = c; break; end
    end
    chk("latency", lat, g_lat);
    chk("read_pulses", rd, g_rd);
    chk("write_pulses", wr, g_wr);
  endtask

  task automatic finish_resp(input int stall);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("stall_resp_valid", {31'd0, bus.resp_valid}, 32'd1);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("post_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [9:0] a, input logic [31:0] wd);
    present(w, sz, sg, a, wd, 1'b1);
    accept_and_measure();
    finish_resp(0);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 10'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'd0, bus.req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_fault", {31'd0, bus.resp_fault}, 32'd0);
    chk("rst_rd_flag",    {31'd0, read_data_flag}, 32'd0);
    chk("rst_wr_flag",    {31'd0, write_data_flag}, 32'd0);
    chk("rst_addr",       {24'd0, address_of_data}, 32'd0);
    chk("rst_dtw",        data_to_write, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_mem();

    // Word store then word load.
    run(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEAD_BEEF);
    chk("mem4_after_sw", mem[4], 32'hDEAD_BEEF);
    chk("model_ldw", model_load(ref_mem[4], 10'h010, SZ_WORD, 1'b0), 32'hDEAD_BEEF);
    run(1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0);

    // Sub-word read-modify-write.
    poke(4, 32'h1122_3344);
    run(1'b1, SZ_BYTE, 1'b0, 10'h012, 32'h0000_00AA);
    chk("mem4_after_sb", mem[4], 32'h11AA_3344);
    run(1'b1, SZ_HALF, 1'b0, 10'h010, 32'h1234_BEEF);
    run(1'b1, SZ_BYTE, 1'b0, 10'h013, 32'hFFFF_FF77);
    chk("mem4_after_sh_sb", mem[4], 32'h77AA_BEEF);
    chk("mem4_vs_model", mem[4], ref_mem[4]);

    // Byte/half loads, both extensions.
    chk("model_lb_s", model_load(ref_mem[4], 10'h012, SZ_BYTE, 1'b1), 32'hFFFF_FFAA);
    run(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'd0);
    run(1'b0, SZ_BYTE, 1'b1, 10'h012, 32'd0);
    run(1'b0, SZ_BYTE, 1'b0, 10'h012, 32'd0);
    run(1'b0, SZ_HALF, 1'b0, 10'h010, 32'd0);
    run(1'b0, SZ_HALF, 1'b1, 10'h010, 32'd0);

    poke(4, 32'h80F1_0000);
    chk("model_lh_s", model_load(ref_mem[4], 10'h012, SZ_HALF, 1'b1), 32'hFFFF_80F1);
    chk("model_lh_u", model_load(ref_mem[4], 10'h012, SZ_HALF, 1'b0), 32'h0000_80F1);
    run(1'b0, SZ_HALF, 1'b1, 10'h012, 32'd0);
    run(1'b0, SZ_HALF, 1'b0, 10'h012, 32'd0);
    run(1'b0, SZ_WORD, 1'b1, 10'h010, 32'd0);

    // Faults: no memory access, zero data.
    run(1'b0, SZ_WORD, 1'b0, 10'h011, 32'd0);
    run(1'b1, SZ_HALF, 1'b0, 10'h013, 32'h0000_1234);
    run(1'b0, 2'b11,   1'b0, 10'h010, 32'd0);
    run(1'b1, SZ_WORD, 1'b0, 10'h016, 32'h5555_5555);
    chk("mem4_after_faults", mem[4], 32'h80F1_0000);

    // Backpressure with a second request waiting.
    present(1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0, 1'b1);
    accept_and_measure();
    @(posedge clk); #1;
    present(1'b0, SZ_HALF, 1'b0, 10'h012, 32'd0, 1'b1);
    finish_resp(5);
    accept_and_measure();
    finish_resp(0);

    // Reset during the RD cycle of a byte store.
    poke(4, 32'h1122_3344);
    present(1'b1, SZ_BYTE, 1'b0, 10'h011, 32'h0000_0055, 1'b0);
    wait_accept();
    chk("midrst_in_rd", {31'd0, read_data_flag}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rd_flag",  {31'd0, read_data_flag}, 32'd0);
    chk("midrst_wr_flag",  {31'd0, write_data_flag}, 32'd0);
    chk("midrst_req_rdy",  {31'd0, bus.req_ready}, 32'd1);
    chk("midrst_resp_vld", {31'd0, bus.resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_mem4", mem[4], 32'h1122_3344);

    // Normal operation after reset.
    run(1'b0, SZ_WORD, 1'b0, 10'h010, 32'd0);
    run(1'b1, SZ_BYTE, 1'b0, 10'h011, 32'h0000_0055);
    chk("mem4_final", mem[4], 32'h1122_5544);

    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
